i2c_txn_sequencer: RTL and testbench

//  Transaction-level sequencer for the byte-level I2C master. Accepts one register

---
 rtl/i2c_txn_sequencer.sv | 136 +++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: expands one register read/write request into a byte-level I2C master command stream
module i2c_txn_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic [2:0] i2c_cmd,
    output logic [7:0] i2c_din,
    output logic       i2c_wr,
    input  logic       i2c_ready,
    input  logic       i2c_ack,
    input  logic [7:0] i2c_dout
);
    localparam logic [2:0] C_START   = 3'b000;
    localparam logic [2:0] C_WR      = 3'b001;
    localparam logic [2:0] C_RD      = 3'b010;
    localparam logic [2:0] C_STOP    = 3'b011;
    localparam logic [2:0] C_RESTART = 3'b100;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT, RESP} state_t;

    state_t          state, state_nx;
    logic            rw;
    logic [6:0]      dev;
    logic [7:0]      rg, wd;
    logic [2:0]      step, last, step_cmd;
    logic [7:0]      step_din;
    logic            ack_q, accept, expired, waiting;
    logic [TW-1:0]   tcnt;

    assign accept    = req_valid && req_ready;
    assign last      = rw ? 3'd6 : 3'd4;
    assign waiting   = state == WAIT_BUSY || state == WAIT_DONE;
    assign expired   = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign rsp_valid = state == RESP;

    // command and byte for the current step of the latched request
    always_comb begin
        step_cmd = C_STOP;
        step_din = 8'h00;
        case (step)
            3'd0: step_cmd = C_START;
            3'd1: begin step_cmd = C_WR; step_din = {dev, 1'b0}; end
            3'd2: begin step_cmd = C_WR; step_din = rg; end
            3'd3: begin step_cmd = rw ? C_RESTART : C_WR; step_din = rw ? 8'h00 : wd; end
            3'd4: begin step_cmd = rw ? C_WR : C_STOP; step_din = rw ? {dev, 1'b1} : 8'h00; end
            3'd5: begin step_cmd = C_RD; step_din = 8'h01; end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state: issue a command, wait for the master to go busy then idle, advance or abort
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (accept) state_nx = ISSUE;
            ISSUE:     if (i2c_ready) state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = expired ? RESP : (!i2c_ready ? WAIT_DONE : WAIT_BUSY);
            WAIT_DONE: state_nx = expired ? RESP : (i2c_ready ? NEXT : WAIT_DONE);
            NEXT:      state_nx = (step == last) ? RESP : ISSUE;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // request latch, command strobe, timeout counter, step advance and response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b0;
            i2c_wr      <= 1'b0;
            i2c_cmd     <= C_START;
            i2c_din     <= 8'h00;
            rw          <= 1'b0;
            dev         <= 7'h00;
            rg          <= 8'h00;
            wd          <= 8'h00;
            step        <= 3'd0;
            ack_q       <= 1'b0;
            tcnt        <= '0;
            rsp_rdata   <= 8'h00;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            req_ready <= state_nx == IDLE;
            i2c_wr    <= state == ISSUE && i2c_ready;
            if (accept) begin
                rw          <= req_rw;
                dev         <= req_dev;
                rg          <= req_reg;
                wd          <= req_wdata;
                step        <= 3'd0;
                rsp_rdata   <= 8'h00;
                rsp_nack    <= 1'b0;
                rsp_timeout <= 1'b0;
            end
            if (state == ISSUE && i2c_ready) begin
                i2c_cmd <= step_cmd;
                i2c_din <= step_din;
                tcnt    <= '0;
            end
            if (waiting) begin
                tcnt <= tcnt + 1'b1;
                if (expired) rsp_timeout <= 1'b1;
                else if (state == WAIT_DONE && i2c_ready) begin
                    if (i2c_cmd == C_WR) ack_q <= i2c_ack;
                    if (i2c_cmd == C_RD) rsp_rdata <= i2c_dout;
                end
            end
            if (state == NEXT && step != last) begin
                if (i2c_cmd == C_WR && ack_q) begin
                    rsp_nack <= 1'b1;
                    step     <= last;
                end else begin
                    step <= step + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed and randomized transactions against a behavioural I2C master and command-list model
module tb_i2c_txn_sequencer;
    localparam logic [2:0] START = 3'b000, WR = 3'b001, RD = 3'b010, STOP = 3'b011, RESTART = 3'b100;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req_valid = 1'b0, req_rw = 1'b0;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
    logic       req_ready, rsp_valid, rsp_nack, rsp_timeout, i2c_wr;
    logic [7:0] rsp_rdata, i2c_din;
    logic [2:0] i2c_cmd;
    logic       i2c_ready = 1'b1, i2c_ack = 1'b0;
    logic [7:0] i2c_dout = 8'h00;

    int          tests = 0, fails = 0, cyc = 0;
    logic [10:0] m_log[$];
    int          m_wr_cyc[$];
    int          m_nack_at = -1;
    bit          m_hang = 1'b0;
    logic [7:0]  m_dout = 8'h00;
    logic [10:0] exp_q[$];

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .i2c_cmd(i2c_cmd), .i2c_din(i2c_din), .i2c_wr(i2c_wr),
        .i2c_ready(i2c_ready), .i2c_ack(i2c_ack), .i2c_dout(i2c_dout)
    );

    always #5 clk = ~clk;

    // cycle counter for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural byte-level master: logs strobes, goes busy for a random time, returns ack/dout
    initial begin : master
        int cnt, wrn;
        logic [2:0] lcmd;
        cnt = 0; wrn = 0; lcmd = START;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i2c_ready = 1'b1;
                cnt = 0;
            end else if (i2c_wr) begin
                m_log.push_back({i2c_cmd, i2c_din});
                m_wr_cyc.push_back(cyc);
                lcmd = i2c_cmd;
                if (i2c_cmd == START) wrn = 0;
                i2c_ready = 1'b0;
                cnt = m_hang ? -1 : int'($urandom_range(1, 4));
            end else if (!i2c_ready) begin
                if (cnt > 0) cnt--;
                if (cnt == 0 || (cnt < 0 && !m_hang)) begin
                    i2c_ready = 1'b1;
                    i2c_ack = (lcmd == WR) ? (wrn == m_nack_at) : 1'($urandom % 2);
                    i2c_dout = (lcmd == RD) ? m_dout : 8'($urandom);
                    if (lcmd == WR) wrn++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected command list: full step list, cut after a NACKed WR (then STOP) or a hung command (no STOP)
    task automatic build(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                         input int nack_at, input int hang_at);
        logic [10:0] full[$];
        int wrn = 0;
        exp_q.delete();
        full.push_back({START, 8'h00});
        full.push_back({WR, dev, 1'b0});
        full.push_back({WR, rg});
        if (rw) begin
            full.push_back({RESTART, 8'h00});
            full.push_back({WR, dev, 1'b1});
            full.push_back({RD, 8'h01});
        end else full.push_back({WR, wd});
        foreach (full[i]) begin
            exp_q.push_back(full[i]);
            if (i == hang_at) return;
            if (full[i][10:8] == WR) begin
                if (wrn == nack_at) break;
                wrn++;
            end
        end
        exp_q.push_back({STOP, 8'h00});
    endtask

    task automatic check_log(input int base);
        logic [10:0] got;
        chk("cmd_count", m_log.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            got = (base + i < m_log.size()) ? m_log[base + i] : 11'h7ff;
            chk($sformatf("cmd[%0d]", i), got, exp_q[i]);
        end
    endtask

    task automatic send(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_drop", req_ready, 0);
    endtask

    task automatic wait_rsp(output int at);
        int n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        at = cyc;
        chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                       input int nack_at, input logic [7:0] dout);
        int base, at;
        logic [7:0] exp_rd;
        base = m_log.size();
        m_nack_at = nack_at;
        m_dout = dout;
        exp_rd = (rw && nack_at < 0) ? dout : 8'h00;
        build(rw, dev, rg, wd, nack_at, -1);
        send(rw, dev, rg, wd);
        wait_rsp(at);
        chk("rsp_nack", rsp_nack, (nack_at >= 0) ? 1 : 0);
        chk("rsp_timeout", rsp_timeout, 0);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        check_log(base);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("ready_after_rsp", req_ready, 1);
        chk("rdata_hold", rsp_rdata, exp_rd);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // directed steps followed by randomized transactions
    initial begin
        int base, at, n;
        logic [10:0] tmp[$], rq[$];
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_i2c_wr", i2c_wr, 0);
        chk("rst_i2c_cmd", i2c_cmd, 0);
        chk("rst_i2c_din", i2c_din, 0);
        chk("rst_flags", {rsp_nack, rsp_timeout, rsp_rdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_clk", req_ready, 0);
        @(negedge clk);
        chk("ready_after_clk", req_ready, 1);

        txn(1'b0, 7'h50, 8'h0B, 8'h0C, -1, 8'h00);
        txn(1'b1, 7'h50, 8'h10, 8'h00, -1, 8'h5A);
        txn(1'b0, 7'h51, 8'h20, 8'h30, 0, 8'h00);

        base = m_log.size();
        m_hang = 1'b1;
        m_nack_at = -1;
        build(1'b0, 7'h50, 8'h01, 8'h02, -1, 0);
        send(1'b0, 7'h50, 8'h01, 8'h02);
        wait_rsp(at);
        chk("to_flag", rsp_timeout, 1);
        chk("to_nack", rsp_nack, 0);
        chk("to_latency", (m_wr_cyc.size() > base) ? at - m_wr_cyc[base] : -1, 64);
        check_log(base);
        repeat (20) @(negedge clk);
        chk("to_no_more_wr", m_log.size() - base, 1);
        chk("to_ready", req_ready, 1);
        m_hang = 1'b0;
        repeat (3) @(negedge clk);

        base = m_log.size();
        m_nack_at = -1;
        m_dout = 8'hC3;
        build(1'b0, 7'h12, 8'h34, 8'h56, -1, -1);
        tmp = exp_q;
        build(1'b1, 7'h3C, 8'h78, 8'h00, -1, -1);
        rq = exp_q;
        exp_q = tmp;
        foreach (rq[i]) exp_q.push_back(rq[i]);
        req_valid = 1'b1; req_rw = 1'b0; req_dev = 7'h12; req_reg = 8'h34; req_wdata = 8'h56;
        @(negedge clk);
        chk("b2b_drop", req_ready, 0);
        req_rw = 1'b1; req_dev = 7'h3C; req_reg = 8'h78; req_wdata = 8'h00;
        wait_rsp(at);
        chk("b2b_wr_nack", rsp_nack, 0);
        chk("b2b_wr_rdata", rsp_rdata, 0);
        @(negedge clk);
        chk("b2b_accept_ready", req_ready, 1);
        @(negedge clk);
        chk("b2b_second_drop", req_ready, 0);
        req_valid = 1'b0;
        wait_rsp(at);
        chk("b2b_rd_rdata", rsp_rdata, 8'hC3);
        chk("b2b_rd_nack", rsp_nack, 0);
        check_log(base);
        @(negedge clk);

        base = m_log.size();
        m_nack_at = -1;
        send(1'b0, 7'h22, 8'h33, 8'h44);
        n = 0;
        while (m_log.size() < base + 3 && n < 500) begin @(negedge clk); n++; end
        chk("rst_mid_reached", m_log.size() - base, 3);
        chk("rst_mid_cmd", (m_log.size() >= base + 3) ? m_log[base + 2] : 11'h7ff, {WR, 8'h33});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", i2c_wr, 0);
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_cmdout", {i2c_cmd, i2c_din}, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready_after", req_ready, 1);
        chk("rst_mid_no_wr", m_log.size() - base, 3);
        txn(1'b0, 7'h2A, 8'h5C, 8'hE7, -1, 8'h00);

        for (int k = 0; k < 16; k++) begin
            int na;
            na = ($urandom % 4 == 0) ? int'($urandom % 3) : -1;
            txn(1'($urandom % 2), 7'($urandom), 8'($urandom), 8'($urandom), na, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
